// File: rtl/t03_sram_ctrl.sv
// Controller for a two-port SRAM: registered write/read ports plus an in-order, credit-limited read response FIFO.
// Define T03_SRAM_CTRL_BYPASS_EN to forward same-cycle write data to a colliding read instead of stalling it.
module t03_sram_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_rvalid,
    input  logic                  rd_rready,
    output logic [DATA_WIDTH-1:0] rd_rdata,
    output logic                  csb0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int CRD_W = $clog2(RESP_DEPTH + 3) + 1;

    logic                  ready_q;
    logic                  csb0_q, csb1_q;
    logic [ADDR_WIDTH-1:0] addr0_q, addr1_q;
    logic [DATA_WIDTH-1:0] din0_q;
    logic                  s1Valid_q, s2Valid_q, s1Byp_q, s2Byp_q;
    logic [DATA_WIDTH-1:0] s1Data_q, s2Data_q;
    logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CRD_W-1:0]      credits;
    logic                  hazard, wrAcc, rdAcc, rdStall, rdToSram, rdBypass;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] pushData;

    assign hazard = rd_valid && wr_valid && (rd_addr == wr_addr);

`ifdef T03_SRAM_CTRL_BYPASS_EN
    assign rdStall  = 1'b0;
    assign rdToSram = rdAcc && !hazard;
    assign rdBypass = rdAcc && hazard;
`else
    assign rdStall  = hazard;
    assign rdToSram = rdAcc;
    assign rdBypass = 1'b0;
`endif

    // A credit is held from read acceptance until its response leaves the FIFO.
    assign credits   = CRD_W'(count_q) + CRD_W'(s1Valid_q) + CRD_W'(s2Valid_q);
    assign wr_ready  = ready_q;
    assign rd_ready  = ready_q && (credits < CRD_W'(RESP_DEPTH)) && !rdStall;
    assign wrAcc     = wr_valid && wr_ready;
    assign rdAcc     = rd_valid && rd_ready;

    assign push      = s2Valid_q;
    assign pushData  = s2Byp_q ? s2Data_q : dout1;
    assign rd_rvalid = (count_q != '0);
    assign pop       = rd_rvalid && rd_rready;
    assign rd_rdata  = rd_rvalid ? mem_q[rdPtr_q] : '0;

    assign csb0  = csb0_q;
    assign addr0 = addr0_q;
    assign din0  = din0_q;
    assign csb1  = csb1_q;
    assign addr1 = addr1_q;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = (wrPtr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = (rdPtr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Two-stage tag pipeline lines up with the SRAM: sample at N+1, dout1 valid for capture at N+2.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ready_q   <= 1'b0;
            csb0_q    <= 1'b1;
            addr0_q   <= '0;
            din0_q    <= '0;
            csb1_q    <= 1'b1;
            addr1_q   <= '0;
            s1Valid_q <= 1'b0;
            s2Valid_q <= 1'b0;
            s1Byp_q   <= 1'b0;
            s2Byp_q   <= 1'b0;
            s1Data_q  <= '0;
            s2Data_q  <= '0;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
        end else begin
            ready_q   <= 1'b1;
            csb0_q    <= !wrAcc;
            if (wrAcc) begin
                addr0_q <= wr_addr;
                din0_q  <= wr_data;
            end
            csb1_q    <= !rdToSram;
            if (rdToSram) begin
                addr1_q <= rd_addr;
            end
            s1Valid_q <= rdAcc;
            s1Byp_q   <= rdBypass;
            s1Data_q  <= wr_data;
            s2Valid_q <= s1Valid_q;
            s2Byp_q   <= s1Byp_q;
            s2Data_q  <= s1Data_q;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= pushData;
        end
    end

endmodule
